// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-ported, variable-latency unified memory
//               between instruction fetch (IF) and load/store (MEM). Data
//               requests have priority; a starvation counter forces a fetch
//               grant after STARVE_MAX consecutive contended data grants.
//               The memory is driven through a held req / one-cycle ack
//               handshake. Read data is returned with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,

    output logic          if_stall,
    output logic          mem_stall
);

    // Starve counter is 4 bits wide, which covers the legal 1..15 range.
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_BUSY = 2'd1,
        S_DM_BUSY = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // Registered state
    state_t          r_state;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_dm_rdata;
    logic            r_if_done;
    logic            r_dm_done;
    logic [3:0]      r_starve;

    // Next-state values
    state_t          w_state_nxt;
    logic            w_mem_req_nxt;
    logic            w_mem_we_nxt;
    logic [AW-1:0]   w_mem_addr_nxt;
    logic [DW-1:0]   w_mem_wdata_nxt;
    logic [DW-1:0]   w_if_rdata_nxt;
    logic [DW-1:0]   w_dm_rdata_nxt;
    logic            w_if_done_nxt;
    logic            w_dm_done_nxt;
    logic [3:0]      w_starve_nxt;

    // Arbitration decision, only meaningful in IDLE
    logic            w_starved;
    logic            w_grant_dm;
    logic            w_grant_if;

    // Fetch wins a contended cycle only once it has been passed over STARVE_MAX times.
    always_comb begin
        w_starved  = if_req && (r_starve == c_starve_max);
        w_grant_dm = dm_req && !w_starved;
        w_grant_if = if_req && !w_grant_dm;
    end

    // Next-state and next-output computation; every registered output is derived here.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_if_done_nxt   = 1'b0;
        w_dm_done_nxt   = 1'b0;
        w_starve_nxt    = r_starve;

        case (r_state)
            S_IDLE: begin
                if (w_grant_dm) begin
                    w_state_nxt     = S_DM_BUSY;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = dm_we;
                    w_mem_addr_nxt  = dm_addr;
                    w_mem_wdata_nxt = dm_wdata;
                    // Only a grant that actually passes over a waiting fetch counts.
                    if (if_req && (r_starve != c_starve_max)) begin
                        w_starve_nxt = r_starve + 4'd1;
                    end
                end else if (w_grant_if) begin
                    w_state_nxt     = S_IF_BUSY;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_wdata_nxt = '0;
                    w_starve_nxt    = 4'd0;
                end
            end

            S_IF_BUSY: begin
                // Request/address stay frozen until the memory acknowledges.
                if (mem_ack) begin
                    w_state_nxt    = S_RESP;
                    w_mem_req_nxt  = 1'b0;
                    w_if_rdata_nxt = mem_rdata;
                    w_if_done_nxt  = 1'b1;
                end
            end

            S_DM_BUSY: begin
                if (mem_ack) begin
                    w_state_nxt    = S_RESP;
                    w_mem_req_nxt  = 1'b0;
                    // A store returns no data; present zero rather than bus junk.
                    w_dm_rdata_nxt = r_mem_we ? '0 : mem_rdata;
                    w_dm_done_nxt  = 1'b1;
                end
            end

            S_RESP: begin
                // Done pulse is visible this cycle; requests get one cycle to settle.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset; reset aborts any access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_starve    <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_dm_done   <= w_dm_done_nxt;
            r_starve    <= w_starve_nxt;
        end
    end

    // Output mapping; the stalls are the only combinational outputs.
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_done   = r_if_done;
    assign dm_done   = r_dm_done;

    assign if_stall  = if_req && !r_if_done;
    assign mem_stall = dm_req && !r_dm_done;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Directed self-checking bench for unified_mem_arbiter. Inputs
//               change and outputs are sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          if_stall;
    logic          mem_stall;

    int n_cmp = 0;
    int n_err = 0;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .if_stall  (if_stall),
        .mem_stall (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contention expectations: STARVE_MAX=4 gives DM x4 then IF then DM.
    int exp_starve [6] = '{1, 2, 3, 4, 0, 1};
    bit exp_is_if  [6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_mem_req",  mem_req,  1'b0);
        check("rst_mem_we",   mem_we,   1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_done",  if_done,  1'b0);
        check("rst_dm_done",  dm_done,  1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_starve",   dut.r_starve, 4'd0);
        reset = 1'b1;
        tick();

        // ---------------- single fetch, ack after 2 cycles ----------------
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        tick();
        check("f_req_c1",   mem_req,  1'b1);
        check("f_addr",     mem_addr, 32'h40);
        check("f_we",       mem_we,   1'b0);
        check("f_stall",    if_stall, 1'b1);
        tick();
        check("f_req_c2",   mem_req,  1'b1);
        check("f_nodone",   if_done,  1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C01_0004;
        tick();
        mem_ack = 1'b0;
        check("f_req_off",  mem_req,  1'b0);
        check("f_done",     if_done,  1'b1);
        check("f_rdata",    if_rdata, 32'h8C01_0004);
        check("f_stall_dn", if_stall, 1'b0);
        check("f_dm_done",  dm_done,  1'b0);
        if_req = 1'b0;
        tick();
        check("f_done_1cy", if_done,  1'b0);
        check("f_idle_req", mem_req,  1'b0);

        // ---------------- contention with 1-cycle acks ----------------
        if_req  = 1'b1;
        if_addr = 32'h0000_1000;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_2000;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("c%0d_addr", k), mem_addr, exp_is_if[k] ? 32'h1000 : 32'h2000);
            check($sformatf("c%0d_starve", k), dut.r_starve, 4'(exp_starve[k]));
            mem_ack   = 1'b1;
            mem_rdata = 32'hA5A5_0000 + 32'(k);
            tick();
            mem_ack = 1'b0;
            check($sformatf("c%0d_ifdone", k), if_done, exp_is_if[k] ? 1'b1 : 1'b0);
            check($sformatf("c%0d_dmdone", k), dm_done, exp_is_if[k] ? 1'b0 : 1'b1);
            if (exp_is_if[k])
                check($sformatf("c%0d_ifrd", k), if_rdata, 32'hA5A5_0000 + 32'(k));
            else
                check($sformatf("c%0d_dmrd", k), dm_rdata, 32'hA5A5_0000 + 32'(k));
            tick();
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();

        // ---------------- store, immediate ack ----------------
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0100;
        dm_wdata = 32'hDEAD_BEEF;
        tick();
        check("s_we",     mem_we,    1'b1);
        check("s_wdata",  mem_wdata, 32'hDEAD_BEEF);
        check("s_addr",   mem_addr,  32'h100);
        check("s_mstall", mem_stall, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        check("s_done",   dm_done,  1'b1);
        check("s_rdata0", dm_rdata, 32'h0);
        check("s_ifdone", if_done,  1'b0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        check("s_done_1cy", dm_done, 1'b0);

        // ---------------- stable handshake, 5-cycle ack ----------------
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0200;
        tick();
        dm_addr = 32'h0000_0300;
        check("h_addr0", mem_addr, 32'h200);
        for (int i = 1; i < 5; i++) begin
            tick();
            check($sformatf("h_addr%0d", i), mem_addr, 32'h200);
            check($sformatf("h_req%0d", i),  mem_req,  1'b1);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0055;
        tick();
        mem_ack = 1'b0;
        check("h_done",  dm_done,  1'b1);
        check("h_rdata", dm_rdata, 32'h55);
        dm_req = 1'b0;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("sp_ifdone", if_done,  1'b0);
        check("sp_dmdone", dm_done,  1'b0);
        check("sp_req",    mem_req,  1'b0);
        check("sp_dmrd",   dm_rdata, 32'h55);

        // ---------------- reset mid-access ----------------
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0400;
        tick();
        check("r_busy_req", mem_req, 1'b1);
        reset = 1'b0;
        tick();
        check("r_req_off", mem_req, 1'b0);
        check("r_nodone",  dm_done, 1'b0);
        reset  = 1'b1;
        dm_req = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 1'b0;
        check("r_ack_dm",  dm_done,  1'b0);
        check("r_ack_req", mem_req,  1'b0);
        check("r_dmrd",    dm_rdata, 32'h0);
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        tick();
        check("r_if_addr", mem_addr, 32'h80);
        check("r_if_req",  mem_req,  1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        check("r_if_done", if_done,  1'b1);
        check("r_if_rd",   if_rdata, 32'h1111_2222);
        if_req = 1'b0;
        tick();

        // ---------------- request withdrawal during IF_BUSY ----------------
        if_req  = 1'b1;
        if_addr = 32'h0000_00C0;
        tick();
        check("w_addr", mem_addr, 32'hC0);
        if_req = 1'b0;
        tick();
        check("w_req_held", mem_req, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0033;
        tick();
        mem_ack = 1'b0;
        check("w_done",  if_done,  1'b1);
        check("w_rdata", if_rdata, 32'h33);
        tick();
        check("w_done_off", if_done, 1'b0);
        check("w_no_new1",  mem_req, 1'b0);
        tick();
        check("w_no_new2",  mem_req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. Accepts level requests from both stages and grants one at a time, with data priority plus an anti-starvation override for fetch. Drives the memory through a req/ack handshake. Returns read data with a one-cycle done pulse, and produces stall signals that the hazard logic ORs into PC/IF_ID hold and pipeline freeze.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, consecutive DM grants made while if_req is pending before IF is forced to win (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
if_req  in  1  fetch request; held until if_done
if_addr  in  AW  fetch address
if_rdata  out  DW  registered fetch data, valid when if_done=1
if_done  out  1  one-cycle completion pulse to IF
dm_req  in  1  data request; held until dm_done
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_rdata  out  DW  registered load data, valid when dm_done=1
dm_done  out  1  one-cycle completion pulse to MEM
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write enable to memory
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion from memory
if_stall  out  1  if_req && !if_done (combinational)
mem_stall  out  1  dm_req && !dm_done (combinational)

Behaviour:
- States: IDLE, IF_BUSY, DM_BUSY, RESP. All outputs are registered except the two stalls.
- Reset (reset=0 at a clk edge): state=IDLE; mem_req, mem_we, if_done, dm_done = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starve counter = 0. Reset applied mid-transaction aborts it: no done pulse is issued and mem_req is low after the edge.
- IDLE, arbitration on the current edge:
  - Both requests low: stay in IDLE.
  - Only one request high: grant it.
  - Both high: grant DM, unless starve==STARVE_MAX, in which case grant IF.
  - On a grant, latch addr/we/wdata (we=0 and wdata=0 for IF), set mem_req=1, and go to IF_BUSY or DM_BUSY.
- BUSY states: mem_req, mem_we, mem_addr, mem_wdata are held stable until mem_ack.
  - On mem_ack, capture mem_rdata into the granted requester's rdata register.
  - Store data capture is don't-care, but dm_rdata must then be 0.
  - Clear mem_req, pulse the granted done=1 for exactly one cycle, and go to RESP.
- RESP: requests are not sampled; the done pulse is active; go to IDLE next edge. This lets requesters drop or change requests before re-arbitration.
- Timing: request sampled at edge 0; mem_req high from edge 0; ack at the earliest in the following cycle; done high one cycle after the ack edge. Minimum 3 cycles per access, and one access at a time.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each DM grant made while if_req=1.
  - Clears on any IF grant.
  - Unchanged on a DM grant while if_req=0.
- mem_ack while in IDLE or RESP is ignored, with no state or data change.
- A requester dropping its req during BUSY does not abort the access; the done pulse is still produced.
- Addresses pass through unmodified; alignment checking is the requester's responsibility.
- Only one of if_done and dm_done is ever high in a cycle.

Test Plan:
- Reset then single fetch: if_req=1, if_addr=0x00000040, memory acks after 2 cycles with mem_rdata=0x8C010004 → mem_req high 2 cycles with mem_addr=0x40 and mem_we=0; if_done pulses once with if_rdata=0x8C010004; if_stall is low during the done cycle.
- Store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, immediate ack → mem_we=1, mem_wdata=0xDEADBEEF; dm_done is a single pulse; dm_rdata=0.
- Contention, STARVE_MAX=4: both requests held continuously with 1-cycle acks → grant order DM, DM, DM, DM, IF, DM…; starve reads 4 before the IF grant and 0 after it.
- Stable handshake: ack delayed 5 cycles with dm_addr changed mid-access → mem_addr keeps the originally latched value for all 5 cycles; a spurious mem_ack in IDLE leaves both done outputs low.
- Reset mid-access: reset=0 during DM_BUSY → next cycle mem_req=0, no dm_done; a later ack is ignored; after release, a new if_req is serviced normally.
- Request withdrawal: if_req dropped during IF_BUSY → the access completes, if_done still pulses, and no new access starts from RESP.
